// File: rtl/hpi_arbiter.sv
// hpi_arbiter: two-requester arbiter and bus sequencer for the CY7C67300 HPI.
// Each transaction runs an ADDRESS register write followed by a DATA register
// read or write, using programmable setup and strobe widths.
// Build option: define HPI_ARB_FIXED_PRIO_EN for fixed priority (r0 wins ties);
// the default build uses round-robin arbitration.
module hpi_arbiter #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  rw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [1:0]  ack,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [1:0]  hpi_address,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  input  logic [15:0] hpi_data_in,
  output logic        hpi_wen,
  output logic        hpi_oen,
  output logic        hpi_csn
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_SETUP,
    ADDR_STROBE,
    ADDR_HOLD,
    DATA_SETUP,
    DATA_STROBE,
    DATA_HOLD,
    DONE
  } state_t;

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  localparam logic [1:0] SEL_ADDRESS = 2'b10;
  localparam logic [1:0] SEL_DATA    = 2'b00;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        gnt, gnt_nxt;
  logic        rw_q, rw_nxt;
  logic [15:0] addr_q, addr_nxt;
  logic [15:0] wdata_q, wdata_nxt;
  logic        win;

`ifdef HPI_ARB_FIXED_PRIO_EN
  // Fixed priority: r0 wins whenever it requests.
  assign win = req[0] ? 1'b0 : 1'b1;
`else
  logic last_gnt;

  // Round-robin: on a tie the requester not granted last wins.
  assign win = (req == 2'b11) ? ~last_gnt : req[1];

  // Remember the most recent grant for the next tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= 1'b1;
    end else if ((state == IDLE) && (|req)) begin
      last_gnt <= win;
    end
  end
`endif

  // Next-state, down-counter and grant-latch computation.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    rw_nxt    = rw_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    unique case (state)
      IDLE: begin
        if (|req) begin
          gnt_nxt   = win;
          rw_nxt    = rw[win];
          addr_nxt  = win ? addr[31:16] : addr[15:0];
          wdata_nxt = win ? wdata[31:16] : wdata[15:0];
          cnt_nxt   = SETUP_LOAD;
          state_nxt = ADDR_SETUP;
        end
      end
      ADDR_SETUP: begin
        if (cnt == '0) begin
          cnt_nxt   = STROBE_LOAD;
          state_nxt = ADDR_STROBE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ADDR_STROBE: begin
        if (cnt == '0) begin
          state_nxt = ADDR_HOLD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ADDR_HOLD: begin
        cnt_nxt   = SETUP_LOAD;
        state_nxt = DATA_SETUP;
      end
      DATA_SETUP: begin
        if (cnt == '0) begin
          cnt_nxt   = STROBE_LOAD;
          state_nxt = DATA_STROBE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DATA_STROBE: begin
        if (cnt == '0) begin
          state_nxt = DATA_HOLD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DATA_HOLD: begin
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State registers plus outputs registered from the next state, so every
  // strobe and bus value changes on the same edge as the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      gnt          <= 1'b0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack          <= '0;
      rdata        <= '0;
      busy         <= 1'b0;
      hpi_address  <= SEL_DATA;
      hpi_data_out <= '0;
      hpi_data_oe  <= 1'b0;
      hpi_wen      <= 1'b1;
      hpi_oen      <= 1'b1;
      hpi_csn      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gnt     <= gnt_nxt;
      rw_q    <= rw_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;

      busy    <= (state_nxt != IDLE);
      hpi_csn <= (state_nxt == IDLE);
      hpi_wen <= !((state_nxt == ADDR_STROBE) ||
                   ((state_nxt == DATA_STROBE) && rw_nxt));
      hpi_oen <= !((state_nxt == DATA_STROBE) && !rw_nxt);
      ack     <= (state_nxt == DONE) ? (gnt_nxt ? 2'b10 : 2'b01) : 2'b00;

      // Sample the bus on the final strobe cycle, while hpi_oen is still low.
      if ((state == DATA_STROBE) && (cnt == '0) && !rw_q) begin
        rdata <= hpi_data_in;
      end

      unique case (state_nxt)
        ADDR_SETUP, ADDR_STROBE, ADDR_HOLD: begin
          hpi_address  <= SEL_ADDRESS;
          hpi_data_out <= addr_nxt;
          hpi_data_oe  <= 1'b1;
        end
        DATA_SETUP, DATA_STROBE, DATA_HOLD: begin
          hpi_address  <= SEL_DATA;
          hpi_data_out <= rw_nxt ? wdata_nxt : 16'h0000;
          hpi_data_oe  <= rw_nxt;
        end
        default: begin
          hpi_address  <= SEL_DATA;
          hpi_data_out <= '0;
          hpi_data_oe  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/hpi_arbiter.md
HPI_ARBITER -- requirements
Module: hpi_arbiter

Interface
REQ-001 Parameter: SETUP_CYCLES, 1, cycles the address and data lines are driven before the strobe falls (legal 1..15).
REQ-002 Parameter: STROBE_CYCLES, 2, cycles hpi_wen or hpi_oen is held low (legal 1..15).
REQ-003 clk  in  1  16 MHz system clock; all state updates on the rising edge.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 req  in  2  per-requester transaction request; bit i is requester i.
REQ-006 rw  in  2  per-requester direction: 1=write, 0=read.
REQ-007 addr  in  32  per-requester CY7C67300 memory address; [15:0] is r0, [31:16] is r1.
REQ-008 wdata  in  32  per-requester write data; [15:0] is r0, [31:16] is r1.
REQ-009 ack  out  2  one-cycle completion pulse to the granted requester.
REQ-010 rdata  out  16  read result, valid while ack is high and held until the next read completes.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 hpi_address  out  2  HPI register select: 2'b10 = ADDRESS, 2'b00 = DATA.
REQ-013 hpi_data_out  out  16  value to drive on the HPI data bus.
REQ-014 hpi_data_oe  out  1  bus-drive enable; the top level builds the tristate from it.
REQ-015 hpi_data_in  in  16  sampled HPI data bus.
REQ-016 hpi_wen, hpi_oen, hpi_csn  out  1 each  active-low HPI strobes and chip select.

Function
REQ-017 States: IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, DATA_SETUP, DATA_STROBE, DATA_HOLD, DONE.
REQ-018 Grant in IDLE: when any req bit is high, the winner's rw, addr and wdata are latched together with its index, and the FSM moves to ADDR_SETUP.
REQ-019 Arbitration: round-robin; when both bits are high, the requester not granted last wins. The last-grant pointer resets to 1, so r0 wins the first tie.
REQ-020 ADDR_SETUP for SETUP_CYCLES, ADDR_STROBE for STROBE_CYCLES, ADDR_HOLD for 1 cycle. Throughout: hpi_address=2'b10, hpi_data_out=latched addr, hpi_data_oe=1. hpi_wen is low only in ADDR_STROBE.
REQ-021 DATA_SETUP for SETUP_CYCLES, DATA_STROBE for STROBE_CYCLES, DATA_HOLD for 1 cycle, all with hpi_address=2'b00.
REQ-022 Write data phase: hpi_data_out=latched wdata, hpi_data_oe=1, and hpi_wen is low only in DATA_STROBE.
REQ-023 Read data phase: hpi_data_oe=0 and hpi_oen is low only in DATA_STROBE. hpi_data_in is captured into rdata on the last DATA_STROBE cycle.
REQ-024 hpi_csn is low in every state except IDLE. hpi_wen and hpi_oen are never low at the same time.
REQ-025 DONE lasts 1 cycle: ack[granted]=1, and the other ack bit stays 0. Next state is IDLE.
REQ-026 Latency: ack rises exactly 2*(SETUP_CYCLES+STROBE_CYCLES+1) cycles after the edge that granted the request (8 with defaults).
REQ-027 IDLE lasts at least 1 cycle between transactions. Back-to-back grants are therefore spaced 2*(SETUP_CYCLES+STROBE_CYCLES+1)+2 cycles apart (10 with defaults).
REQ-028 Requester obligations: hold req high until ack. The requester then drops req or presents a new transaction; the arbiter never grants in the ack cycle.
REQ-029 If req drops mid-transaction, the transaction still completes and ack still pulses. Changes to addr, wdata or rw after the grant are ignored.
REQ-030 A single 4-bit down-counter times the SETUP and STROBE states. All outputs are registered.

Reset
REQ-031 Reset values: hpi_wen=1, hpi_oen=1, hpi_csn=1, hpi_data_oe=0, hpi_address=2'b00, hpi_data_out=0, ack=0, rdata=0, busy=0, state=IDLE, last-grant pointer=1, counter=0.
REQ-032 Reset asserted mid-transaction returns all strobes high on the next edge. That transaction issues no ack.

Configuration
REQ-033 Macro HPI_ARB_FIXED_PRIO_EN: when defined, r0 always wins a tie and the last-grant pointer is not implemented. When undefined, round-robin per REQ-019 applies.

Verification
REQ-034 Test 1: r0 write, addr=16'h1324, wdata=16'hCAFE, defaults. Expect the ADDRESS phase to drive 16'h1324 with hpi_wen low for 2 cycles, then the DATA phase to drive 16'hCAFE with hpi_wen low for 2 cycles. Expect ack=2'b01 exactly 8 cycles after the grant.
REQ-035 Test 2: r1 read, addr=16'h0500, bench drives hpi_data_in=16'hBEEF while hpi_oen is low. Expect hpi_data_oe=0 in the data phase, ack=2'b10 and rdata=16'hBEEF.
REQ-036 Test 3: req=2'b11 held across 4 transactions. Expect grant order r0, r1, r0, r1, or r0 four times with HPI_ARB_FIXED_PRIO_EN defined.
REQ-037 Test 4: reset pulsed during the r0 ADDR_STROBE. Expect hpi_wen=1, hpi_csn=1 and busy=0 on the next edge, and no ack.
REQ-038 Test 5: SETUP_CYCLES=3, STROBE_CYCLES=4, r0 drops req one cycle after the grant. Expect the transaction to complete with ack after 16 cycles, and no second grant.
